// File: rtl/shift_cmd_queue.sv
// Command FIFO feeding the combinational barrel shifter, with a registered
// valid/ready result stage so bursty producers and stalling consumers decouple.
module shift_cmd_queue #(
  parameter int DEPTH = 4,
  parameter int DW    = 8,
  parameter int SW    = 3,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_din,
  input  logic [SW-1:0] in_shamt,
  input  logic          in_aorl,
  input  logic          in_lorr,
  output logic [DW-1:0] sh_din,
  output logic [SW-1:0] sh_shamt,
  output logic          sh_aorl,
  output logic          sh_lorr,
  input  logic [DW-1:0] sh_dout,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [CW-1:0] count
);

  typedef struct packed {
    logic [DW-1:0] din;
    logic [SW-1:0] shamt;
    logic          aorl;
    logic          lorr;
  } cmd_t;

  cmd_t          mem [DEPTH];
  cmd_t          head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          not_empty;
  logic          push;
  logic          pop;

  assign not_empty = (count != '0);
  // in_ready depends only on occupancy, never on out_ready.
  assign in_ready  = rst_n & (count != CW'(DEPTH));
  assign push      = in_valid & in_ready;
  assign pop       = not_empty & (~out_valid | out_ready);

  assign head     = not_empty ? mem[rd_ptr] : '0;
  assign sh_din   = head.din;
  assign sh_shamt = head.shamt;
  assign sh_aorl  = head.aorl;
  assign sh_lorr  = head.lorr;

  // Storage is intentionally not reset; occupancy gates what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_din, in_shamt, in_aorl, in_lorr};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (pop) begin
      out_valid <= 1'b1;
      out_data  <= sh_dout;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_cmd_queue.sv
// Bench for shift_cmd_queue: golden shifter on sh_*, queue-based reference model
// compared every cycle, plus directed literal checks for the key scenarios.
module tb_shift_cmd_queue;

  typedef struct packed {
    logic [7:0] din;
    logic [2:0] shamt;
    logic       aorl;
    logic       lorr;
  } cmd_t;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_din;
  logic [2:0] in_shamt;
  logic       in_aorl;
  logic       in_lorr;
  logic [7:0] sh_din;
  logic [2:0] sh_shamt;
  logic       sh_aorl;
  logic       sh_lorr;
  logic [7:0] sh_dout;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] count;

  shift_cmd_queue dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_din    (in_din),
    .in_shamt  (in_shamt),
    .in_aorl   (in_aorl),
    .in_lorr   (in_lorr),
    .sh_din    (sh_din),
    .sh_shamt  (sh_shamt),
    .sh_aorl   (sh_aorl),
    .sh_lorr   (sh_lorr),
    .sh_dout   (sh_dout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  function automatic logic [7:0] golden(cmd_t c);
    if (c.lorr) return c.din << c.shamt;
    else if (c.aorl) return $signed(c.din) >>> c.shamt;
    else return c.din >> c.shamt;
  endfunction

  always_comb sh_dout = golden({sh_din, sh_shamt, sh_aorl, sh_lorr});

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int         vectors = 0;
  int         miscompares = 0;
  cmd_t       mq[$];
  logic [7:0] got[$];
  logic       m_ov;
  logic [7:0] m_od;
  bit         last_push;
  int         pushes = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(cmd_t c);
    {in_din, in_shamt, in_aorl, in_lorr} = c;
  endtask

  task automatic drive_rand();
    in_din   = 8'($urandom);
    in_shamt = 3'($urandom);
    in_aorl  = 1'($urandom);
    in_lorr  = 1'($urandom);
  endtask

  // One clock: log the handshake, advance the model, compare all outputs.
  task automatic step();
    logic       dv;
    logic [7:0] dd;
    bit         m_rdy, m_pop, m_push;
    cmd_t       head;
    dv = out_valid;
    dd = out_data;
    @(posedge clk);
    if (dv && out_ready) got.push_back(dd);
    m_rdy = rst_n && (mq.size() != 4);
    last_push = 1'b0;
    if (!rst_n) begin
      mq.delete();
      m_ov = 1'b0;
      m_od = 8'h00;
    end else begin
      m_pop  = (mq.size() != 0) && (!m_ov || out_ready);
      m_push = in_valid && m_rdy;
      if (m_pop) begin
        m_od = golden(mq[0]);
        m_ov = 1'b1;
        void'(mq.pop_front());
      end else if (m_ov && out_ready) begin
        m_ov = 1'b0;
      end
      if (m_push) begin
        mq.push_back({in_din, in_shamt, in_aorl, in_lorr});
        pushes++;
      end
      last_push = m_push;
    end
    #1;
    head = (mq.size() != 0) ? mq[0] : '0;
    check("out_valid", 32'(out_valid), 32'(m_ov));
    check("out_data", 32'(out_data), 32'(m_od));
    check("count", 32'(count), 32'(mq.size()));
    check("in_ready", 32'(in_ready), 32'(rst_n && (mq.size() != 4)));
    check("sh_cmd", 32'({sh_din, sh_shamt, sh_aorl, sh_lorr}), 32'(head));
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 50 && (mq.size() != 0 || m_ov); n++) step();
    check("drain_done", 32'(mq.size() == 0 && !m_ov), 32'd1);
  endtask

  cmd_t t3[6];
  int   k;
  int   base;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_din = '0; in_shamt = '0; in_aorl = 1'b0; in_lorr = 1'b0;
    m_ov = 1'b0; m_od = 8'h00;
    step(); step();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    #3 rst_n = 1'b1;
    step();

    // T1: single command, minimum latency
    drive({8'hB4, 3'd3, 1'b0, 1'b0}); in_valid = 1'b1;
    step();
    check("t1_count_after_push", 32'(count), 32'd1);
    in_valid = 1'b0;
    step();
    check("t1_out_valid", 32'(out_valid), 32'd1);
    check("t1_out_data", 32'(out_data), 32'h16);
    check("t1_count_back", 32'(count), 32'd0);
    drain();

    // T2: ordering of back-to-back commands
    got.delete();
    in_valid = 1'b1;
    drive({8'hB4, 3'd2, 1'b1, 1'b0}); step();
    drive({8'hB4, 3'd1, 1'b0, 1'b1}); step();
    drive({8'hB4, 3'd0, 1'b0, 1'b0}); step();
    drain();
    check("t2_n", 32'(got.size()), 32'd3);
    if (got.size() == 3) begin
      check("t2_r0", 32'(got[0]), 32'hED);
      check("t2_r1", 32'(got[1]), 32'h68);
      check("t2_r2", 32'(got[2]), 32'hB4);
    end

    // T3: full queue with backpressure
    for (int i = 0; i < 6; i++) begin
      t3[i].din   = 8'h81 + 8'(i * 37);
      t3[i].shamt = 3'(i + 1);
      t3[i].aorl  = 1'(i);
      t3[i].lorr  = (i > 2);
    end
    got.delete();
    out_ready = 1'b0; in_valid = 1'b1; k = 0;
    for (int n = 0; n < 12; n++) begin
      drive(t3[k < 6 ? k : 5]);
      step();
      if (last_push) k++;
    end
    check("t3_accepted", 32'(k), 32'd5);
    check("t3_full_count", 32'(count), 32'd4);
    check("t3_full_ready", 32'(in_ready), 32'd0);
    for (int n = 0; n < 10; n++) begin
      step();
      check("t3_hold_valid", 32'(out_valid), 32'd1);
      check("t3_hold_data", 32'(out_data), 32'(golden(t3[0])));
    end
    out_ready = 1'b1;
    for (int n = 0; n < 20 && k < 6; n++) begin
      drive(t3[k]);
      step();
      if (last_push) k++;
    end
    check("t3_sixth_accepted", 32'(k), 32'd6);
    drain();
    check("t3_n", 32'(got.size()), 32'd6);
    if (got.size() == 6)
      for (int i = 0; i < 6; i++) check("t3_order", 32'(got[i]), 32'(golden(t3[i])));

    // T4: simultaneous push and pop at count 2, pointers wrap
    got.delete(); base = pushes;
    out_ready = 1'b0; in_valid = 1'b1;
    for (int n = 0; n < 10 && mq.size() != 2; n++) begin
      drive_rand();
      step();
    end
    out_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      drive_rand();
      step();
      check("t4_count", 32'(count), 32'd2);
    end
    drain();
    check("t4_n", 32'(got.size()), 32'(pushes - base));

    // T5: async reset mid-cycle with queued work and a pending result
    out_ready = 1'b0; in_valid = 1'b1;
    for (int n = 0; n < 10 && mq.size() != 3; n++) begin
      drive_rand();
      step();
    end
    check("t5_pre_count", 32'(count), 32'd3);
    check("t5_pre_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check("t5_rst_valid", 32'(out_valid), 32'd0);
    check("t5_rst_data", 32'(out_data), 32'd0);
    check("t5_rst_count", 32'(count), 32'd0);
    check("t5_rst_ready", 32'(in_ready), 32'd0);
    step(); step();
    #3 rst_n = 1'b1;
    got.delete();
    out_ready = 1'b1;
    drive({8'h96, 3'd2, 1'b1, 1'b0}); in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("t5_post_valid", 32'(out_valid), 32'd1);
    check("t5_post_data", 32'(out_data), 32'hE5);
    step(); step();
    check("t5_post_n", 32'(got.size()), 32'd1);
    check("t5_post_r0", (got.size() > 0) ? 32'(got[0]) : 32'hFFFF, 32'hE5);

    // T6: random traffic with varying duty cycles
    begin
      int duty_in, duty_out, n;
      got.delete(); base = pushes;
      duty_in = 100; duty_out = 100;
      for (n = 0; n < 40000 && (pushes - base) < 2000; n++) begin
        if (n % 200 == 0) begin
          duty_in  = $urandom_range(10, 100);
          duty_out = $urandom_range(10, 100);
        end
        in_valid  = ($urandom_range(1, 100) <= duty_in);
        out_ready = ($urandom_range(1, 100) <= duty_out);
        drive_rand();
        step();
      end
      check("t6_all_pushed", 32'(pushes - base), 32'd2000);
      drain();
      check("t6_n", 32'(got.size()), 32'(pushes - base));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
